mul_rs: RTL and testbench
=========================

Name: mul_rs

Overview:
- Tomasulo reservation station for the multiply functional unit. It acts as the initiator on the unit's operand/enable interface and as the acknowledging consumer on its result interface.
- Holds up to ENTRIES pending multiplies and resolves source operands by snooping the common data bus (CDB).
- Issues one ready operation at a time to the multiplier, then forwards the unit's answer to the CDB arbiter. The arbiter's grant is returned to the multiplier as the result acknowledge.

Parameters:
ENTRIES, 3, number of RS entries (1..7)
TAG_W, 4, width of producer tags; tag 0 means "value present, no producer"
BASE_TAG, 4'd4, tag of entry 0; entry i owns tag BASE_TAG+i (all non-zero)

Ports:
clk  in  1  clock
nRST  in  1  async active-low reset
dispValid  in  1  dispatch request this cycle
dispReady  out  1  at least one entry FREE (registered state, not same-cycle frees)
dispQj  in  TAG_W  producer tag of operand 1 (0 = dispVj valid)
dispVj  in  32  operand 1 value
dispQk  in  TAG_W  producer tag of operand 2 (0 = dispVk valid)
dispVk  in  32  operand 2 value
dispTag  out  TAG_W  tag assigned to the dispatched op (lowest FREE index)
cdbValid  in  1  CDB broadcast valid
cdbTag  in  TAG_W  CDB tag
cdbData  in  32  CDB value
fuAvailable  in  1  multiplier can accept an op this cycle
fuState  in  3  multiplier state code (shared state constants)
fuResult  in  32  multiplier result, valid in answer state
fuInEN  out  1  start multiply with fuData1/fuData2
fuData1  out  32  operand 1 to unit
fuData2  out  32  operand 2 to unit
fuResultAC  out  1  result accepted; equals cdbReq && cdbGrant
cdbReq  out  1  request CDB slot; high iff fuState == answer and an entry is EXEC
cdbReqTag  out  TAG_W  tag of EXEC entry
cdbReqData  out  32  equals fuResult
cdbGrant  in  1  arbiter grant

Behaviour:
- Reset:
  - All entries FREE; Q fields 0, V fields 0.
  - Registered outputs 0.
  - dispReady = 1 after reset.
  - Reset mid-operation discards all in-flight work. No cdbReq may appear until a new issue.
- Per-entry state: FREE -> WAIT (any Q != 0) or READY (both Q == 0) -> EXEC -> FREE.
- Dispatch (dispValid && dispReady):
  - Allocates the lowest FREE index; dispTag reports it combinationally.
  - Same-cycle bypass: if cdbValid and cdbTag equals the incoming dispQj/dispQk, capture cdbData and store Q = 0.
- Snoop: every WAIT entry compares Qj/Qk against cdbTag when cdbValid.
  - On a match: V <= cdbData, Q <= 0.
  - Entry moves to READY the cycle after its last operand arrives.
  - The block's own broadcast (cdbTag of a mul) is snooped like any other.
- Issue:
  - fuInEN = fuAvailable && (some READY entry) && no entry in EXEC after this cycle's free.
  - Selects the lowest READY index; fuData1/2 driven combinationally from that entry.
  - The entry becomes EXEC at the clock edge. At most one EXEC entry at any time.
- Completion: cdbReq is asserted while fuState == answer.
  - On cdbGrant, the EXEC entry becomes FREE and fuResultAC is pulsed the same cycle.
  - Without a grant, cdbReq, cdbReqTag and cdbReqData hold stable. The unit stalls in answer.
- Back-to-back: fuAvailable is combinationally high on the grant cycle.
  - fuInEN may issue a new READY entry in that same cycle.
  - The freed entry is not reallocatable by dispatch until the next cycle.
- Simultaneous events are all legal in one cycle: dispatch, snoop and grant. Grant-free and dispatch-alloc never target the same entry.
- Full: dispReady = 0; dispValid is ignored.
- Any fuState other than idle or answer: no cdbReq.

Decomposition:
- Shared header (the team's state/opcode include):
  - multiplier state codes (idle, answer)
  - tag width
  - NO_TAG = 0
  - BASE_TAG for the mul station
- Sub-module rs_entry: one entry's state, Q/V registers, CDB compare and bypass logic.
- Top level holds:
  - lowest-index priority encoders for free and ready entries
  - the single-EXEC tracker
  - the FU and CDB muxing

Test Plan:
- Dispatch Qj=0,Vj=6,Qk=0,Vk=7 with FU idle -> fuInEN the cycle after dispatch with data 6/7. Unit reaches answer, cdbReq with tag 4 and data 42. Grant -> fuResultAC=1, entry FREE, dispReady stays 1.
- Dispatch Qj=9,Vk=3, then CDB tag 9 data 5 -> entry READY next cycle. Issue 5*3 -> CDB result 15 on tag 4.
- Dispatch with Qk=9 while cdbValid, cdbTag=9, data 11 in the same cycle -> operand captured, entry READY, result = Vj*11.
- Fill 3 entries -> dispReady=0, a 4th dispValid is ignored. Grant on entry 0 -> dispReady=1 the next cycle, new op gets tag 4.
- Hold cdbGrant=0 for 5 cycles in answer -> cdbReq/tag/data stable and no new fuInEN. Grant with a second op READY -> fuResultAC and fuInEN both high in the same cycle.
- Assert nRST low while an op is EXEC -> all entries FREE, cdbReq=0, fuInEN=0. Post-reset dispatch proceeds normally.

Source files
------------

// File: rtl/mul_rs_pkg.sv
// mul_rs_pkg
// Shared constants for the multiply reservation station: multiplier state
// codes seen on fuState, tag width, the "no producer" tag, the station's
// base tag and the per-entry state encoding.
package mul_rs_pkg;

    localparam int                   MUL_TAG_W    = 4;
    localparam logic [MUL_TAG_W-1:0] NO_TAG       = '0;
    localparam logic [MUL_TAG_W-1:0] MUL_BASE_TAG = 4'd4;

    // Multiplier state codes shared with the functional unit.
    localparam logic [2:0] FU_IDLE   = 3'd0;
    localparam logic [2:0] FU_ANSWER = 3'd2;

    typedef enum logic [1:0] {
        ENT_FREE  = 2'd0,
        ENT_WAIT  = 2'd1,
        ENT_READY = 2'd2,
        ENT_EXEC  = 2'd3
    } ent_state_e;

endpackage

// File: rtl/mul_rs_entry.sv
// rs_entry
// One reservation-station entry: lifecycle state, operand tags (Q) and
// values (V), CDB snoop while waiting, and same-cycle CDB bypass at dispatch.
//
// Ports:
//   clk, nRST                     clock, async active-low reset
//   alloc_i                       dispatch writes this entry (only honoured when FREE)
//   disp_qj_i/vj_i, disp_qk_i/vk_i  incoming operand tags and values
//   cdb_valid_i/tag_i/data_i      common data bus broadcast
//   issue_i                       READY entry is sent to the multiplier
//   release_i                     EXEC entry's result was granted onto the CDB
//   free_o, ready_o               state flags for the top-level encoders
//   vj_o, vk_o                    stored operand values
//
// state     | meaning
// ----------+--------------------------------------------------------
// ENT_FREE  | unallocated, available to dispatch
// ENT_WAIT  | allocated, at least one operand still has a producer tag
// ENT_READY | both operands present, waiting for the multiplier
// ENT_EXEC  | handed to the multiplier, waiting for the CDB grant
module rs_entry
    import mul_rs_pkg::*;
#(
    parameter int TAG_W = MUL_TAG_W
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             alloc_i,
    input  logic [TAG_W-1:0] disp_qj_i,
    input  logic [31:0]      disp_vj_i,
    input  logic [TAG_W-1:0] disp_qk_i,
    input  logic [31:0]      disp_vk_i,
    input  logic             cdb_valid_i,
    input  logic [TAG_W-1:0] cdb_tag_i,
    input  logic [31:0]      cdb_data_i,
    input  logic             issue_i,
    input  logic             release_i,
    output logic             free_o,
    output logic             ready_o,
    output logic [31:0]      vj_o,
    output logic [31:0]      vk_o
);

    localparam logic [TAG_W-1:0] NONE = TAG_W'(NO_TAG);

    ent_state_e       state_q;
    logic [TAG_W-1:0] qj_q, qj_d, qk_q, qk_d;
    logic [31:0]      vj_q, vj_d, vk_q, vk_d;
    logic             opnds_ok;

    // Next Q/V: dispatch capture with bypass, or snoop while waiting.
    // A zero tag never matches, so a broadcast on tag 0 cannot clobber values.
    always_comb begin
        qj_d = qj_q;
        vj_d = vj_q;
        qk_d = qk_q;
        vk_d = vk_q;
        if (state_q == ENT_FREE && alloc_i) begin
            qj_d = disp_qj_i;
            vj_d = disp_vj_i;
            qk_d = disp_qk_i;
            vk_d = disp_vk_i;
            if (cdb_valid_i && disp_qj_i != NONE && cdb_tag_i == disp_qj_i) begin
                qj_d = NONE;
                vj_d = cdb_data_i;
            end
            if (cdb_valid_i && disp_qk_i != NONE && cdb_tag_i == disp_qk_i) begin
                qk_d = NONE;
                vk_d = cdb_data_i;
            end
        end else if (state_q == ENT_WAIT && cdb_valid_i) begin
            if (qj_q != NONE && cdb_tag_i == qj_q) begin
                qj_d = NONE;
                vj_d = cdb_data_i;
            end
            if (qk_q != NONE && cdb_tag_i == qk_q) begin
                qk_d = NONE;
                vk_d = cdb_data_i;
            end
        end
    end

    assign opnds_ok = (qj_d == NONE) && (qk_d == NONE);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= ENT_FREE;
            qj_q    <= '0;
            qk_q    <= '0;
            vj_q    <= '0;
            vk_q    <= '0;
        end else begin
            qj_q <= qj_d;
            qk_q <= qk_d;
            vj_q <= vj_d;
            vk_q <= vk_d;
            case (state_q)
                ENT_FREE:  if (alloc_i)   state_q <= opnds_ok ? ENT_READY : ENT_WAIT;
                ENT_WAIT:  if (opnds_ok)  state_q <= ENT_READY;
                ENT_READY: if (issue_i)   state_q <= ENT_EXEC;
                ENT_EXEC:  if (release_i) state_q <= ENT_FREE;
                default:                  state_q <= ENT_FREE;
            endcase
        end
    end

    assign free_o  = (state_q == ENT_FREE);
    assign ready_o = (state_q == ENT_READY);
    assign vj_o    = vj_q;
    assign vk_o    = vk_q;

endmodule

// File: rtl/mul_rs.sv
// mul_rs
// Reservation station in front of the multiply unit. Holds ENTRIES pending
// multiplies, resolves operands from the CDB, issues one ready op at a time
// to the multiplier and forwards its answer to the CDB arbiter.
//
// Ports:
//   clk, nRST                          clock, async active-low reset
//   dispValid/dispQj/dispVj/dispQk/dispVk  dispatch request and operands
//   dispReady, dispTag                 a FREE entry exists / tag it will get
//   cdbValid/cdbTag/cdbData            CDB snoop
//   fuAvailable, fuState, fuResult     multiplier status and answer
//   fuInEN, fuData1, fuData2           start a multiply
//   fuResultAC                         answer accepted (grant seen)
//   cdbReq/cdbReqTag/cdbReqData        CDB slot request with the answer
//   cdbGrant                           arbiter grant
module mul_rs
    import mul_rs_pkg::*;
#(
    parameter int               ENTRIES  = 3,
    parameter int               TAG_W    = MUL_TAG_W,
    parameter logic [TAG_W-1:0] BASE_TAG = MUL_BASE_TAG
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             dispValid,
    output logic             dispReady,
    input  logic [TAG_W-1:0] dispQj,
    input  logic [31:0]      dispVj,
    input  logic [TAG_W-1:0] dispQk,
    input  logic [31:0]      dispVk,
    output logic [TAG_W-1:0] dispTag,
    input  logic             cdbValid,
    input  logic [TAG_W-1:0] cdbTag,
    input  logic [31:0]      cdbData,
    input  logic             fuAvailable,
    input  logic [2:0]       fuState,
    input  logic [31:0]      fuResult,
    output logic             fuInEN,
    output logic [31:0]      fuData1,
    output logic [31:0]      fuData2,
    output logic             fuResultAC,
    output logic             cdbReq,
    output logic [TAG_W-1:0] cdbReqTag,
    output logic [31:0]      cdbReqData,
    input  logic             cdbGrant
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0] ent_free, ent_ready, ent_alloc, ent_issue, ent_rel;
    logic [31:0]        ent_vj [ENTRIES];
    logic [31:0]        ent_vk [ENTRIES];

    logic             free_any, ready_any;
    logic [IDX_W-1:0] free_idx, ready_idx;
    logic [31:0]      sel_vj, sel_vk;

    logic             exec_valid_q, exec_valid_d;
    logic [IDX_W-1:0] exec_idx_q, exec_idx_d;
    logic             disp_fire, grant_fire;

    // Lowest-index priority encoders; walking downward lets the lowest win.
    always_comb begin
        free_any  = 1'b0;
        free_idx  = '0;
        ready_any = 1'b0;
        ready_idx = '0;
        sel_vj    = '0;
        sel_vk    = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (ent_free[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (ent_ready[i]) begin
                ready_any = 1'b1;
                ready_idx = IDX_W'(i);
                sel_vj    = ent_vj[i];
                sel_vk    = ent_vk[i];
            end
        end
    end

    // Free flags come from registered state, so an entry released by this
    // cycle's grant is not visible to dispatch until the next cycle.
    assign dispReady  = free_any;
    assign dispTag    = BASE_TAG + TAG_W'(free_idx);
    assign disp_fire  = dispValid && free_any;

    assign cdbReq     = exec_valid_q && (fuState == FU_ANSWER);
    assign grant_fire = cdbReq && cdbGrant;
    assign fuResultAC = grant_fire;
    assign cdbReqTag  = BASE_TAG + TAG_W'(exec_idx_q);
    assign cdbReqData = fuResult;

    // Issue allowed only if the EXEC slot is empty or is vacated this cycle.
    assign fuInEN  = fuAvailable && ready_any && (!exec_valid_q || grant_fire);
    assign fuData1 = sel_vj;
    assign fuData2 = sel_vk;

    always_comb begin
        exec_valid_d = exec_valid_q;
        exec_idx_d   = exec_idx_q;
        if (grant_fire) begin
            exec_valid_d = 1'b0;
        end
        if (fuInEN) begin
            exec_valid_d = 1'b1;
            exec_idx_d   = ready_idx;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            exec_valid_q <= 1'b0;
            exec_idx_q   <= '0;
        end else begin
            exec_valid_q <= exec_valid_d;
            exec_idx_q   <= exec_idx_d;
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
        assign ent_alloc[g] = disp_fire  && (free_idx   == IDX_W'(g));
        assign ent_issue[g] = fuInEN     && (ready_idx  == IDX_W'(g));
        assign ent_rel[g]   = grant_fire && (exec_idx_q == IDX_W'(g));

        rs_entry #(
            .TAG_W(TAG_W)
        ) u_entry (
            .clk         (clk),
            .nRST        (nRST),
            .alloc_i     (ent_alloc[g]),
            .disp_qj_i   (dispQj),
            .disp_vj_i   (dispVj),
            .disp_qk_i   (dispQk),
            .disp_vk_i   (dispVk),
            .cdb_valid_i (cdbValid),
            .cdb_tag_i   (cdbTag),
            .cdb_data_i  (cdbData),
            .issue_i     (ent_issue[g]),
            .release_i   (ent_rel[g]),
            .free_o      (ent_free[g]),
            .ready_o     (ent_ready[g]),
            .vj_o        (ent_vj[g]),
            .vk_o        (ent_vk[g])
        );
    end

endmodule

// File: tb/tb_mul_rs.sv
module tb_mul_rs;
    import mul_rs_pkg::*;

    localparam logic [2:0] FU_BUSY = 3'd1;

    logic        clk = 1'b0;
    logic        nRST;
    logic        dispValid;
    logic        dispReady;
    logic [3:0]  dispQj, dispQk, dispTag;
    logic [31:0] dispVj, dispVk;
    logic        cdbValid;
    logic [3:0]  cdbTag;
    logic [31:0] cdbData;
    logic        fuAvailable;
    logic [2:0]  fuState;
    logic [31:0] fuResult;
    logic        fuInEN;
    logic [31:0] fuData1, fuData2;
    logic        fuResultAC;
    logic        cdbReq;
    logic [3:0]  cdbReqTag;
    logic [31:0] cdbReqData;
    logic        cdbGrant;

    int checks = 0;
    int errors = 0;

    // Small multiplier model: two busy cycles, then answer until granted.
    logic        fu_clr;
    logic [2:0]  fu_st;
    logic [31:0] fu_res;
    int          fu_cnt;

    always #5 clk = ~clk;

    mul_rs dut (
        .clk        (clk),
        .nRST       (nRST),
        .dispValid  (dispValid),
        .dispReady  (dispReady),
        .dispQj     (dispQj),
        .dispVj     (dispVj),
        .dispQk     (dispQk),
        .dispVk     (dispVk),
        .dispTag    (dispTag),
        .cdbValid   (cdbValid),
        .cdbTag     (cdbTag),
        .cdbData    (cdbData),
        .fuAvailable(fuAvailable),
        .fuState    (fuState),
        .fuResult   (fuResult),
        .fuInEN     (fuInEN),
        .fuData1    (fuData1),
        .fuData2    (fuData2),
        .fuResultAC (fuResultAC),
        .cdbReq     (cdbReq),
        .cdbReqTag  (cdbReqTag),
        .cdbReqData (cdbReqData),
        .cdbGrant   (cdbGrant)
    );

    always @(posedge clk) begin
        if (fu_clr) begin
            fu_st  <= FU_IDLE;
            fu_cnt <= 0;
            fu_res <= '0;
        end else begin
            case (fu_st)
                FU_IDLE: if (fuInEN) begin
                    fu_res <= fuData1 * fuData2;
                    fu_cnt <= 2;
                    fu_st  <= FU_BUSY;
                end
                FU_BUSY: if (fu_cnt == 1) fu_st <= FU_ANSWER;
                         else fu_cnt <= fu_cnt - 1;
                FU_ANSWER: if (cdbGrant) begin
                    if (fuInEN) begin
                        fu_res <= fuData1 * fuData2;
                        fu_cnt <= 2;
                        fu_st  <= FU_BUSY;
                    end else begin
                        fu_st <= FU_IDLE;
                    end
                end
                default: fu_st <= FU_IDLE;
            endcase
        end
    end

    assign fuState     = fu_st;
    assign fuResult    = fu_res;
    assign fuAvailable = (fu_st == FU_IDLE) || (fu_st == FU_ANSWER && cdbGrant);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [3:0] qj, input logic [31:0] vj,
                        input logic [3:0] qk, input logic [31:0] vk);
        dispValid = 1'b1;
        dispQj    = qj;
        dispVj    = vj;
        dispQk    = qk;
        dispVk    = vk;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (cdbReq !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, {31'd0, cdbReq}, 32'd1);
    endtask

    initial begin
        nRST      = 1'b0;
        fu_clr    = 1'b1;
        dispValid = 1'b0;
        dispQj    = '0;
        dispVj    = '0;
        dispQk    = '0;
        dispVk    = '0;
        cdbValid  = 1'b0;
        cdbTag    = '0;
        cdbData   = '0;
        cdbGrant  = 1'b0;
        repeat (3) tick();
        check("rst_dispReady", {31'd0, dispReady}, 32'd1);
        check("rst_cdbReq", {31'd0, cdbReq}, 32'd0);
        check("rst_fuInEN", {31'd0, fuInEN}, 32'd0);
        check("rst_dispTag", {28'd0, dispTag}, 32'd4);
        check("rst_fuResultAC", {31'd0, fuResultAC}, 32'd0);
        check("rst_fuData1", fuData1, 32'd0);
        nRST   = 1'b1;
        fu_clr = 1'b0;
        tick();

        // 1: both operands present, 6*7
        disp(4'd0, 32'd6, 4'd0, 32'd7);
        #1;
        check("t1_dispTag", {28'd0, dispTag}, 32'd4);
        check("t1_no_issue_at_disp", {31'd0, fuInEN}, 32'd0);
        tick();
        dispValid = 1'b0;
        #1;
        check("t1_fuInEN", {31'd0, fuInEN}, 32'd1);
        check("t1_fuData1", fuData1, 32'd6);
        check("t1_fuData2", fuData2, 32'd7);
        tick();
        check("t1_no_reissue", {31'd0, fuInEN}, 32'd0);
        wait_req("t1_cdbReq");
        check("t1_reqTag", {28'd0, cdbReqTag}, 32'd4);
        check("t1_reqData", cdbReqData, 32'd42);
        cdbGrant = 1'b1;
        #1;
        check("t1_resultAC", {31'd0, fuResultAC}, 32'd1);
        tick();
        cdbGrant = 1'b0;
        #1;
        check("t1_req_dropped", {31'd0, cdbReq}, 32'd0);
        check("t1_dispReady", {31'd0, dispReady}, 32'd1);

        // 2: operand 1 arrives from the CDB one cycle after dispatch
        disp(4'd9, 32'd0, 4'd0, 32'd3);
        tick();
        dispValid = 1'b0;
        #1;
        check("t2_wait_no_issue", {31'd0, fuInEN}, 32'd0);
        cdbValid = 1'b1;
        cdbTag   = 4'd9;
        cdbData  = 32'd5;
        #1;
        check("t2_snoop_not_same_cycle", {31'd0, fuInEN}, 32'd0);
        tick();
        cdbValid = 1'b0;
        #1;
        check("t2_fuInEN", {31'd0, fuInEN}, 32'd1);
        check("t2_fuData1", fuData1, 32'd5);
        check("t2_fuData2", fuData2, 32'd3);
        tick();
        wait_req("t2_cdbReq");
        check("t2_reqTag", {28'd0, cdbReqTag}, 32'd4);
        check("t2_reqData", cdbReqData, 32'd15);
        cdbGrant = 1'b1;
        tick();
        cdbGrant = 1'b0;

        // 3: same-cycle bypass of operand 2 at dispatch
        disp(4'd0, 32'd4, 4'd9, 32'd0);
        cdbValid = 1'b1;
        cdbTag   = 4'd9;
        cdbData  = 32'd11;
        #1;
        check("t3_dispTag", {28'd0, dispTag}, 32'd4);
        tick();
        dispValid = 1'b0;
        cdbValid  = 1'b0;
        #1;
        check("t3_fuInEN", {31'd0, fuInEN}, 32'd1);
        check("t3_fuData1", fuData1, 32'd4);
        check("t3_fuData2", fuData2, 32'd11);
        tick();
        wait_req("t3_cdbReq");
        check("t3_reqData", cdbReqData, 32'd44);
        cdbGrant = 1'b1;
        tick();
        cdbGrant = 1'b0;

        // 4: fill all entries, a fourth dispatch is ignored
        disp(4'd0, 32'd2, 4'd0, 32'd3);
        #1;
        check("t4_tagA", {28'd0, dispTag}, 32'd4);
        tick();
        disp(4'd9, 32'd0, 4'd0, 32'd2);
        #1;
        check("t4_tagB", {28'd0, dispTag}, 32'd5);
        check("t4_issueA", {31'd0, fuInEN}, 32'd1);
        tick();
        disp(4'd9, 32'd0, 4'd0, 32'd3);
        #1;
        check("t4_tagC", {28'd0, dispTag}, 32'd6);
        tick();
        disp(4'd0, 32'd100, 4'd0, 32'd100);
        #1;
        check("t4_full", {31'd0, dispReady}, 32'd0);
        tick();
        dispValid = 1'b0;
        #1;
        check("t4_still_full", {31'd0, dispReady}, 32'd0);
        wait_req("t4_cdbReq");
        check("t4_reqTag", {28'd0, cdbReqTag}, 32'd4);
        check("t4_reqData", cdbReqData, 32'd6);
        cdbGrant = 1'b1;
        #1;
        check("t4_resultAC", {31'd0, fuResultAC}, 32'd1);
        check("t4_no_same_cycle_free", {31'd0, dispReady}, 32'd0);
        check("t4_no_issue_waiting", {31'd0, fuInEN}, 32'd0);
        tick();
        cdbGrant = 1'b0;
        #1;
        check("t4_dispReady_back", {31'd0, dispReady}, 32'd1);
        check("t4_freed_tag", {28'd0, dispTag}, 32'd4);
        disp(4'd0, 32'd5, 4'd0, 32'd5);
        tick();
        dispValid = 1'b0;
        #1;
        check("t4_issueD", {31'd0, fuInEN}, 32'd1);
        check("t4_D_data1", fuData1, 32'd5);
        check("t4_D_data2", fuData2, 32'd5);
        tick();

        // 5: wake B and C while D executes, then stall D's answer
        cdbValid = 1'b1;
        cdbTag   = 4'd9;
        cdbData  = 32'd7;
        tick();
        cdbValid = 1'b0;
        #1;
        check("t5_blocked_by_exec", {31'd0, fuInEN}, 32'd0);
        wait_req("t5_cdbReq");
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_req", {31'd0, cdbReq}, 32'd1);
            check("t5_hold_tag", {28'd0, cdbReqTag}, 32'd4);
            check("t5_hold_data", cdbReqData, 32'd25);
            check("t5_hold_no_issue", {31'd0, fuInEN}, 32'd0);
            tick();
        end
        cdbGrant = 1'b1;
        #1;
        check("t5_resultAC", {31'd0, fuResultAC}, 32'd1);
        check("t5_b2b_issue", {31'd0, fuInEN}, 32'd1);
        check("t5_B_data1", fuData1, 32'd7);
        check("t5_B_data2", fuData2, 32'd2);
        tick();
        cdbGrant = 1'b0;
        wait_req("t5_B_cdbReq");
        check("t5_B_tag", {28'd0, cdbReqTag}, 32'd5);
        check("t5_B_data", cdbReqData, 32'd14);
        cdbGrant = 1'b1;
        #1;
        check("t5_C_issue", {31'd0, fuInEN}, 32'd1);
        check("t5_C_data2", fuData2, 32'd3);
        tick();
        cdbGrant = 1'b0;
        #1;

        // 6: reset while C is executing
        nRST = 1'b0;
        #1;
        check("t6_cdbReq", {31'd0, cdbReq}, 32'd0);
        check("t6_fuInEN", {31'd0, fuInEN}, 32'd0);
        check("t6_dispReady", {31'd0, dispReady}, 32'd1);
        check("t6_dispTag", {28'd0, dispTag}, 32'd4);
        tick();
        nRST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_no_stale_req", {31'd0, cdbReq}, 32'd0);
            check("t6_no_stale_issue", {31'd0, fuInEN}, 32'd0);
        end
        fu_clr = 1'b1;
        tick();
        fu_clr = 1'b0;
        disp(4'd0, 32'd3, 4'd0, 32'd4);
        #1;
        check("t6_post_tag", {28'd0, dispTag}, 32'd4);
        tick();
        dispValid = 1'b0;
        #1;
        check("t6_post_issue", {31'd0, fuInEN}, 32'd1);
        check("t6_post_data1", fuData1, 32'd3);
        check("t6_post_data2", fuData2, 32'd4);
        tick();
        wait_req("t6_post_cdbReq");
        check("t6_post_reqTag", {28'd0, cdbReqTag}, 32'd4);
        check("t6_post_reqData", cdbReqData, 32'd12);
        cdbGrant = 1'b1;
        #1;
        check("t6_post_resultAC", {31'd0, fuResultAC}, 32'd1);
        tick();
        cdbGrant = 1'b0;
        #1;
        check("t6_post_req_dropped", {31'd0, cdbReq}, 32'd0);
        check("t6_post_dispReady", {31'd0, dispReady}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
